branch_target_table: RTL and testbench
======================================

Name: branch_target_table

Overview:
- Programmable, parametrised successor to the fixed label-to-PC branch lookup.
- Maps a branch label to a next-PC from a writable table with per-entry valid bits, instead of hard-wired constants.
- Sits between the decoder and the fetch PC mux.
- Entries are loaded by the boot/program loader and can then be locked against further writes.
- Reads are registered, with a hit/miss indication.

Parameters:
- LABEL_W, 8, label width in bits.
- PC_W, 12, program counter width in bits.
- DEPTH, 64, number of table entries; must satisfy DEPTH <= 2**LABEL_W.
- DEFAULT_PC, 0, PC returned on a miss or an out-of-range label.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rd_req  in  1  lookup request.
- rd_label  in  LABEL_W  label to look up.
- rd_valid  out  1  lookup result valid; asserted 1 cycle after rd_req.
- rd_pc  out  PC_W  looked-up next PC.
- rd_hit  out  1  entry was valid and in range.
- wr_en  in  1  write request.
- wr_label  in  LABEL_W  entry to write.
- wr_pc  in  PC_W  target PC to store.
- wr_ready  out  1  table accepts writes this cycle.
- wr_err  out  1  one-cycle pulse on a rejected write.
- lock_req  in  1  freeze the table (sticky until reset).
- locked  out  1  table is frozen.
- init_busy  out  1  valid-bit clear sweep in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- Reset values (on any edge where rst_n=0):
  - state=INIT, sweep index=0.
  - rd_valid=0, rd_pc=DEFAULT_PC, rd_hit=0, wr_err=0, locked=0, init_busy=1, wr_ready=0.
- FSM states: INIT, RUN, LOCKED.
- INIT:
  - Clears one valid bit per cycle, index 0..DEPTH-1, so the sweep takes DEPTH cycles.
  - Moves to RUN on the cycle after index DEPTH-1 is cleared.
  - init_busy=1 and wr_ready=0 throughout; wr_en is ignored, with no wr_err, and the writer must hold.
  - lock_req is ignored.
- RUN:
  - wr_ready=1. A write happens when wr_en=1.
  - In-range write (wr_label < DEPTH): stores wr_pc and sets the entry's valid bit at the clock edge.
  - Out-of-range write: no update; wr_err pulses the next cycle.
  - lock_req=1 moves the FSM to LOCKED next cycle. A write in that same cycle is still performed (write before lock).
- LOCKED:
  - locked=1, wr_ready=0.
  - Any wr_en pulses wr_err the next cycle; the table is unchanged.
  - Exited only by reset.
- Read path, fixed 1-cycle latency in all states:
  - rd_valid(t+1)=rd_req(t). Back-to-back requests are supported, one per cycle.
  - In-range label with valid bit set: rd_hit=1, rd_pc=stored PC.
  - Otherwise (invalid entry, out-of-range label, or INIT state): rd_hit=0, rd_pc=DEFAULT_PC.
  - rd_pc and rd_hit hold their last values while rd_valid=0.
- Simultaneous read and accepted write to the same label, same cycle: write-first bypass. The read returns wr_pc with rd_hit=1.
- A read during INIT of an entry whose valid bit is not yet swept still returns a miss, because INIT forces a miss.
- Reset mid-operation: any in-flight read is dropped (rd_valid=0 next cycle). Table contents are invalidated by a new INIT sweep. The lock is released.
- Rewriting a valid entry in RUN overwrites it with no error.

Decomposition:
- Shared package bt_pkg:
  - bt_state_e enum {INIT, RUN, LOCKED}.
  - Default LABEL_W and PC_W localparams.
  - Typedefs label_t and pc_t.
- One sub-module, bt_storage:
  - DEPTH x PC_W register array plus valid-bit vector.
  - One write port and one clear port.
  - Combinational read with range check.
- The top level holds the FSM, sweep counter, bypass logic, and output registers.

Test Plan:
- Reset then idle: init_busy=1 for exactly 64 cycles, then 0; wr_ready rises on the same cycle. A read of label 5 during INIT gives rd_valid=1, rd_hit=0, rd_pc=0.
- RUN: write label 3 -> PC 201, then read label 3 -> next cycle rd_valid=1, rd_hit=1, rd_pc=201. A read of unwritten label 4 gives rd_hit=0, rd_pc=0.
- Same-cycle write label 10 -> PC 278 with read of label 10: rd_pc=278, rd_hit=1 on the next cycle.
- Write label 70 (out of range, DEPTH=64): wr_err=1 for one cycle; a read of label 70 gives rd_hit=0, rd_pc=0.
- Write label 2 -> PC 323 together with lock_req, then write label 2 -> PC 99: locked=1, second write gives wr_err=1, and a read of label 2 returns 323.
- While locked, with a read of label 2 in flight, assert rst_n=0 for one cycle:
  - next cycle rd_valid=0, locked=0, init_busy=1;
  - after the sweep, a read of label 2 gives rd_hit=0.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared types and default widths for the programmable branch target table.
package bt_pkg;

  localparam int LABEL_W_DEF = 8;
  localparam int PC_W_DEF    = 12;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } bt_state_e;

  typedef logic [LABEL_W_DEF-1:0] label_t;
  typedef logic [PC_W_DEF-1:0]    pc_t;

endpackage

// File: rtl/bt_storage.sv
// Branch target storage: PC register array plus per-entry valid bits.
// It has one write port, one valid-clear port and a range-checked combinational read.
module bt_storage
  import bt_pkg::*;
#(
  parameter int LABEL_W = LABEL_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int DEPTH   = 64,
  parameter int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [LABEL_W-1:0] i_wr_label,
  input  logic [PC_W-1:0]    i_wr_pc,
  input  logic               i_clr_en,
  input  logic [IDX_W-1:0]   i_clr_idx,
  input  logic [LABEL_W-1:0] i_rd_label,
  output logic               o_rd_valid,
  output logic [PC_W-1:0]    o_rd_pc
);

  localparam logic [LABEL_W:0] DEPTH_L = (LABEL_W+1)'(DEPTH);

  logic [PC_W-1:0]    r_pc [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic               w_wr_in_range;
  logic               w_rd_in_range;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [IDX_W-1:0]   w_rd_idx;

  assign w_wr_in_range = ({1'b0, i_wr_label} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, i_rd_label} < DEPTH_L);
  assign w_wr_idx      = i_wr_label[IDX_W-1:0];
  assign w_rd_idx      = i_rd_label[IDX_W-1:0];

  // Out-of-range writes are dropped here as well, so the caller cannot alias entries
  always_ff @(posedge clk) begin
    if (i_wr_en && w_wr_in_range) begin
      r_pc[w_wr_idx]    <= i_wr_pc;
      r_valid[w_wr_idx] <= 1'b1;
    end else if (i_clr_en) begin
      r_valid[i_clr_idx] <= 1'b0;
    end
  end

  assign o_rd_valid = w_rd_in_range && r_valid[w_rd_idx];
  assign o_rd_pc    = r_pc[w_rd_idx];

endmodule

// File: rtl/branch_target_table.sv
// Writable, lockable label-to-PC lookup between the decoder and the fetch PC mux.
// Holds the init/run/locked FSM, valid-bit sweep, write-first bypass and registered read outputs.
module branch_target_table
  import bt_pkg::*;
#(
  parameter int              LABEL_W    = LABEL_W_DEF,
  parameter int              PC_W       = PC_W_DEF,
  parameter int              DEPTH      = 64,
  parameter logic [PC_W-1:0] DEFAULT_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_req,
  input  logic [LABEL_W-1:0] rd_label,
  output logic               rd_valid,
  output logic [PC_W-1:0]    rd_pc,
  output logic               rd_hit,
  input  logic               wr_en,
  input  logic [LABEL_W-1:0] wr_label,
  input  logic [PC_W-1:0]    wr_pc,
  output logic               wr_ready,
  output logic               wr_err,
  input  logic               lock_req,
  output logic               locked,
  output logic               init_busy
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LABEL_W:0] DEPTH_L  = (LABEL_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  bt_state_e        r_state;
  bt_state_e        w_state_nxt;
  logic [IDX_W-1:0] r_sweep;
  logic             r_rd_valid;
  logic [PC_W-1:0]  r_rd_pc;
  logic             r_rd_hit;
  logic             r_wr_err;

  logic             w_wr_in_range;
  logic             w_wr_accept;
  logic             w_wr_reject;
  logic             w_clr_en;
  logic             w_store_valid;
  logic [PC_W-1:0]  w_store_pc;

  assign w_wr_in_range = ({1'b0, wr_label} < DEPTH_L);
  assign w_wr_accept   = (r_state == RUN) && wr_en && w_wr_in_range;
  assign w_wr_reject   = wr_en && (((r_state == RUN) && !w_wr_in_range) || (r_state == LOCKED));
  assign w_clr_en      = (r_state == INIT);

  bt_storage #(
    .LABEL_W (LABEL_W),
    .PC_W    (PC_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W)
  ) u_storage (
    .clk        (clk),
    .i_wr_en    (w_wr_accept),
    .i_wr_label (wr_label),
    .i_wr_pc    (wr_pc),
    .i_clr_en   (w_clr_en),
    .i_clr_idx  (r_sweep),
    .i_rd_label (rd_label),
    .o_rd_valid (w_store_valid),
    .o_rd_pc    (w_store_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_sweep <= r_sweep + 1'b1;
    end
  end

  // LOCKED is only left through reset; a write alongside lock_req still lands
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (r_sweep == LAST_IDX) w_state_nxt = RUN;
      RUN:     if (lock_req) w_state_nxt = LOCKED;
      LOCKED:  w_state_nxt = LOCKED;
      default: w_state_nxt = INIT;
    endcase
  end

  // Read results update only on a request; INIT forces a miss, a same-label accepted write bypasses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= DEFAULT_PC;
      r_rd_hit   <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      r_wr_err   <= w_wr_reject;
      if (rd_req) begin
        if (r_state == INIT) begin
          r_rd_pc  <= DEFAULT_PC;
          r_rd_hit <= 1'b0;
        end else if (w_wr_accept && (wr_label == rd_label)) begin
          r_rd_pc  <= wr_pc;
          r_rd_hit <= 1'b1;
        end else if (w_store_valid) begin
          r_rd_pc  <= w_store_pc;
          r_rd_hit <= 1'b1;
        end else begin
          r_rd_pc  <= DEFAULT_PC;
          r_rd_hit <= 1'b0;
        end
      end
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_pc     = r_rd_pc;
  assign rd_hit    = r_rd_hit;
  assign wr_err    = r_wr_err;
  assign init_busy = (r_state == INIT);
  assign wr_ready  = (r_state == RUN);
  assign locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_branch_target_table.sv
// Directed scoreboard bench for branch_target_table: reads push expected results,
// a negedge monitor pops them whenever rd_valid is high.
module tb_branch_target_table;

  localparam int LABEL_W = 8;
  localparam int PC_W    = 12;
  localparam int DEPTH   = 64;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            hit;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               rd_req;
  logic [LABEL_W-1:0] rd_label;
  logic               rd_valid;
  logic [PC_W-1:0]    rd_pc;
  logic               rd_hit;
  logic               wr_en;
  logic [LABEL_W-1:0] wr_label;
  logic [PC_W-1:0]    wr_pc;
  logic               wr_ready;
  logic               wr_err;
  logic               lock_req;
  logic               locked;
  logic               init_busy;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   failCount = 0;

  branch_target_table #(
    .LABEL_W    (LABEL_W),
    .PC_W       (PC_W),
    .DEPTH      (DEPTH),
    .DEFAULT_PC ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_label  (rd_label),
    .rd_valid  (rd_valid),
    .rd_pc     (rd_pc),
    .rd_hit    (rd_hit),
    .wr_en     (wr_en),
    .wr_label  (wr_label),
    .wr_pc     (wr_pc),
    .wr_ready  (wr_ready),
    .wr_err    (wr_err),
    .lock_req  (lock_req),
    .locked    (locked),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle with rd_valid high consumes one expected lookup result
  always @(negedge clk) begin
    if (rd_valid) begin
      exp_t e;
      vecCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL read_unexpected: got pc=%0d hit=%0b, required no result", rd_pc, rd_hit);
      end else begin
        e = expQ.pop_front();
        if (rd_pc !== e.pc || rd_hit !== e.hit) begin
          failCount++;
          $display("[TB] FAIL read_result: got pc=%0d hit=%0b, required pc=%0d hit=%0b",
                   rd_pc, rd_hit, e.pc, e.hit);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus; a read also queues its hand-computed result
  task automatic applyStimulus(input logic doRd, input int rLabel, input int expPc, input logic expHit,
                               input logic doWr, input int wLabel, input int wPc, input logic doLock);
    rd_req   = doRd;
    rd_label = LABEL_W'(rLabel);
    wr_en    = doWr;
    wr_label = LABEL_W'(wLabel);
    wr_pc    = PC_W'(wPc);
    lock_req = doLock;
    if (doRd) expQ.push_back('{pc: PC_W'(expPc), hit: expHit});
    tick();
    rd_req   = 1'b0;
    wr_en    = 1'b0;
    lock_req = 1'b0;
  endtask

  task automatic waitSweep(input string name);
    int cycles = 0;
    while (init_busy && cycles < 200) begin
      tick();
      cycles++;
    end
    checkOutput(name, cycles, DEPTH);
  endtask

  initial begin
    int cycles;
    rst_n = 1'b0; rd_req = 1'b0; rd_label = '0; wr_en = 1'b0;
    wr_label = '0; wr_pc = '0; lock_req = 1'b0;
    tick();
    tick();
    checkOutput("rst_rd_valid",  int'(rd_valid),  0);
    checkOutput("rst_rd_pc",     int'(rd_pc),     0);
    checkOutput("rst_rd_hit",    int'(rd_hit),    0);
    checkOutput("rst_wr_err",    int'(wr_err),    0);
    checkOutput("rst_locked",    int'(locked),    0);
    checkOutput("rst_init_busy", int'(init_busy), 1);
    checkOutput("rst_wr_ready",  int'(wr_ready),  0);

    // First INIT cycle: read label 5 (forced miss) and an ignored write to label 1
    rst_n = 1'b1;
    applyStimulus(1'b1, 5, 0, 1'b0, 1'b1, 1, 555, 1'b0);
    checkOutput("init_wr_err",   int'(wr_err),   0);
    checkOutput("init_wr_ready", int'(wr_ready), 0);
    cycles = 1;
    while (init_busy && cycles < 200) begin
      tick();
      cycles++;
    end
    checkOutput("init_cycles",      cycles,          DEPTH);
    checkOutput("run_wr_ready",     int'(wr_ready),  1);
    checkOutput("run_init_busy",    int'(init_busy), 0);

    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 3, 201, 1'b0);
    applyStimulus(1'b1, 3, 201, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 4, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 10, 278, 1'b1, 1'b1, 10, 278, 1'b0);
    applyStimulus(1'b1, 3, 201, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 3, 400, 1'b0);
    checkOutput("rewrite_wr_err", int'(wr_err), 0);
    applyStimulus(1'b1, 3, 400, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 63, 77, 1'b0);
    applyStimulus(1'b1, 63, 77, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 64, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 70, 500, 1'b0);
    checkOutput("oor_wr_err_pulse", int'(wr_err), 1);
    applyStimulus(1'b1, 70, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("oor_wr_err_clear", int'(wr_err), 0);

    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 2, 323, 1'b1);
    checkOutput("lock_locked",   int'(locked),   1);
    checkOutput("lock_wr_ready", int'(wr_ready), 0);
    checkOutput("lock_wr_err",   int'(wr_err),   0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 2, 99, 1'b0);
    checkOutput("locked_wr_err", int'(wr_err), 1);
    applyStimulus(1'b1, 2, 323, 1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    checkOutput("hold_rd_pc",  int'(rd_pc),  323);
    checkOutput("hold_rd_hit", int'(rd_hit), 1);
    checkOutput("lock_sticky", int'(locked), 1);

    // Reset lands on the same edge as a read of label 2, so that read is dropped
    rst_n = 1'b0;
    rd_req = 1'b1;
    rd_label = LABEL_W'(2);
    tick();
    rst_n = 1'b1;
    rd_req = 1'b0;
    checkOutput("rst2_rd_valid",  int'(rd_valid),  0);
    checkOutput("rst2_locked",    int'(locked),    0);
    checkOutput("rst2_init_busy", int'(init_busy), 1);
    waitSweep("rst2_sweep_cycles");
    applyStimulus(1'b1, 2, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    tick();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
